acl_avg: RTL



---
 rtl/acl_avg.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/acl_avg.sv
// Decimating boxcar averager for the 24-bit accelerometer word (X/Y/Z, 8-bit signed each).
// Samples once per SAMPLE_DIV cycles and emits a per-axis 2^LOG2_N moving average.
module acl_avg #(
  parameter int LOG2_N     = 3,
  parameter int SAMPLE_DIV = 1000000
) (
  input  logic        CLK100MHZ,
  input  logic        reset_n,
  input  logic [23:0] acl_data,
  input  logic        clear,
  output logic [23:0] avg_data,
  output logic        avg_valid,
  output logic        filled,
  output logic        busy
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 8 + LOG2_N;
  localparam int FW = LOG2_N + 1;
  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0]     TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0]     FILL_MAX  = FW'(N);
  localparam logic [LOG2_N-1:0] WPTR_LAST = LOG2_N'(N - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [23:0]             s1_q, s2_q, new_q;
  logic [LOG2_N-1:0]       wptr_q, wptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic signed [SW-1:0]    sum_q [3];
  logic signed [SW-1:0]    sum_d [3];
  logic [23:0]             avg_q, avg_d;
  logic                    valid_q, valid_d;
  logic                    capture;
  logic                    buf_we;
  logic [23:0]             buf_wdata;
  logic [23:0]             old_w;
  logic                    tick;
  logic                    stable;

  // Window storage: no reset, contents are only zeroed by walking through ST_CLEAR.
  logic [23:0] win_mem [N];

  function automatic logic signed [SW-1:0] sext8(input logic [7:0] v);
    return $signed({{LOG2_N{v[7]}}, v});
  endfunction

  assign old_w  = win_mem[wptr_q];
  assign tick   = (cnt_q == TICK_LAST);
  assign stable = (s1_q == s2_q);

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    avg_d     = avg_q;
    valid_d   = 1'b0;
    capture   = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = '0;
    for (int a = 0; a < 3; a++) sum_d[a] = sum_q[a];
    cnt_d = (state_q == ST_CLEAR) ? '0 : (tick ? '0 : cnt_q + CW'(1));

    unique case (state_q)
      ST_CLEAR: begin
        buf_we = 1'b1;
        wptr_d = wptr_q + LOG2_N'(1);
        fill_d = '0;
        for (int a = 0; a < 3; a++) sum_d[a] = '0;
        if (wptr_q == WPTR_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (tick) begin
          if (stable) begin
            state_d = ST_UPDATE;
            capture = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (stable) begin
          state_d = ST_UPDATE;
          capture = 1'b1;
        end
      end
      ST_UPDATE: begin
        buf_we    = 1'b1;
        buf_wdata = new_q;
        wptr_d    = wptr_q + LOG2_N'(1);
        if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
        for (int a = 0; a < 3; a++) begin
          sum_d[a] = sum_q[a] + sext8(new_q[8*a +: 8]) - sext8(old_w[8*a +: 8]);
          avg_d[8*a +: 8] = 8'(sum_d[a] >>> LOG2_N);
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase

    // A flush wins over everything; a coinciding update still writes but publishes nothing.
    if (clear) begin
      state_d = ST_CLEAR;
      wptr_d  = '0;
      cnt_d   = '0;
      fill_d  = '0;
      valid_d = 1'b0;
      avg_d   = avg_q;
      for (int a = 0; a < 3; a++) sum_d[a] = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      s1_q    <= '0;
      s2_q    <= '0;
      new_q   <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
      for (int a = 0; a < 3; a++) sum_q[a] <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= acl_data;
      s2_q    <= s1_q;
      if (capture) new_q <= s2_q;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      avg_q   <= avg_d;
      valid_q <= valid_d;
      for (int a = 0; a < 3; a++) sum_q[a] <= sum_d[a];
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (buf_we) win_mem[wptr_q] <= buf_wdata;
  end

  assign avg_data  = avg_q;
  assign avg_valid = valid_q;
  assign filled    = (fill_q == FILL_MAX);
  assign busy      = (state_q == ST_CLEAR);

endmodule
